// File: rtl/multi_lane_dispatcher.sv
// Multi-lane dispatcher: issues up to NUM_LANES unique activations per beat from a
// repetition-annotated activation group, each tagged with its in-group index and the current weight.
module mld_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         avail_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && (cnt_q != (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // Two free slots leave room for a push already in flight when avail drops.
    assign avail_o = (cnt_q <= (AW+1)'(DEPTH - 2));
    assign dout_o  = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

module multi_lane_dispatcher #(
    parameter int GROUP_SIZE    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_LANES     = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int LOG_MAX_ITERS = 16,
    parameter int LOG_MAX_READS = 16,
    localparam int REP_INFO = GROUP_SIZE * GROUP_SIZE,
    localparam int IW       = GROUP_SIZE * DATA_WIDTH + REP_INFO,
    localparam int LW       = DATA_WIDTH + $clog2(GROUP_SIZE),
    localparam int OW       = NUM_LANES * LW + DATA_WIDTH + REP_INFO
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     configure,
    input  logic [LOG_MAX_ITERS-1:0] num_iters,
    input  logic [LOG_MAX_READS-1:0] num_reads_per_iter,
    input  logic                     dedup_en,
    input  logic [IW-1:0]            act_data_in,
    input  logic                     act_valid_in,
    output logic                     act_avail_out,
    input  logic [DATA_WIDTH-1:0]    weight_data_in,
    input  logic                     weight_valid_in,
    output logic                     weight_avail_out,
    output logic [OW-1:0]            data_out,
    output logic [NUM_LANES-1:0]     lane_valid_out,
    output logic                     last_out,
    output logic                     valid_out,
    input  logic                     avail_in,
    output logic                     done_out
);
    localparam int G    = GROUP_SIZE;
    localparam int DW   = DATA_WIDTH;
    localparam int L    = NUM_LANES;
    localparam int IDXW = $clog2(G);
    localparam int CW   = $clog2(G + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [LOG_MAX_ITERS-1:0] iters_q, iters_d;
    logic [LOG_MAX_READS-1:0] reads_q, reads_d, reads_ld_q, reads_ld_d;
    logic                     dedup_q, dedup_d, first_q, first_d;
    logic [G-1:0]             pend_q, pend_d;

    logic [IW-1:0]       act_head;
    logic [DW-1:0]       w_head;
    logic                act_empty, w_empty, act_pop, w_pop;
    logic [REP_INFO-1:0] rep;
    logic [G-1:0]        diag, cand, issued;
    logic [L-1:0]        lv;
    logic [L*LW-1:0]     lanes;
    logic [CW-1:0]       pop_cnt;
    logic [IDXW-1:0]     idx_v;
    logic                last, show, fire;

    mld_fifo #(.W(IW), .DEPTH(FIFO_DEPTH)) u_act_fifo (
        .clk(clk), .rst(rst), .push_i(act_valid_in), .din_i(act_data_in), .pop_i(act_pop),
        .dout_o(act_head), .empty_o(act_empty), .avail_o(act_avail_out)
    );

    mld_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_w_fifo (
        .clk(clk), .rst(rst), .push_i(weight_valid_in), .din_i(weight_data_in), .pop_i(w_pop),
        .dout_o(w_head), .empty_o(w_empty), .avail_o(weight_avail_out)
    );

    assign rep  = act_head[IW-1 -: REP_INFO];
    assign cand = first_q ? diag : pend_q;

    always_comb begin
        diag = '0;
        for (int i = 0; i < G; i++) diag[i] = dedup_q ? rep[i*G + i] : 1'b1;
    end

    // Walk the candidate mask low-to-high, packing the first L set indices into lanes.
    always_comb begin
        lanes   = '0;
        lv      = '0;
        issued  = '0;
        pop_cnt = '0;
        idx_v   = '0;
        for (int i = 0; i < G; i++) begin
            if (cand[i]) begin
                idx_v = IDXW'(i);
                for (int k = 0; k < L; k++) begin
                    if (pop_cnt == CW'(k)) begin
                        lanes[k*LW +: LW] = {idx_v, act_head[i*DW +: DW]};
                        lv[k]             = 1'b1;
                        issued[i]         = 1'b1;
                    end
                end
                pop_cnt = pop_cnt + 1'b1;
            end
        end
    end

    assign last    = (pop_cnt <= CW'(L));
    assign show    = (state_q == S_RUN) && !act_empty && !w_empty;
    assign fire    = show && !configure && avail_in;
    assign act_pop = fire && last;
    assign w_pop   = fire && last && (reads_q == LOG_MAX_READS'(1));

    assign valid_out      = fire;
    assign lane_valid_out = show ? lv : '0;
    assign last_out       = show && last;
    assign data_out       = show ? {rep, w_head, lanes} : '0;
    assign done_out       = (state_q == S_DONE);

    always_comb begin
        state_d    = state_q;
        iters_d    = iters_q;
        reads_d    = reads_q;
        reads_ld_d = reads_ld_q;
        dedup_d    = dedup_q;
        first_d    = first_q;
        pend_d     = pend_q;
        if (configure) begin
            iters_d    = num_iters;
            reads_d    = num_reads_per_iter;
            reads_ld_d = num_reads_per_iter;
            dedup_d    = dedup_en;
            first_d    = 1'b1;
            pend_d     = '0;
            state_d    = (num_iters == '0 || num_reads_per_iter == '0) ? S_DONE : S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (fire) begin
                        if (last) begin
                            first_d = 1'b1;
                            pend_d  = '0;
                            if (reads_q == LOG_MAX_READS'(1)) begin
                                reads_d = reads_ld_q;
                                if (iters_q == LOG_MAX_ITERS'(1)) state_d = S_DONE;
                                else iters_d = iters_q - 1'b1;
                            end else begin
                                reads_d = reads_q - 1'b1;
                            end
                        end else begin
                            pend_d  = cand & ~issued;
                            first_d = 1'b0;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            iters_q    <= '0;
            reads_q    <= '0;
            reads_ld_q <= '0;
            dedup_q    <= 1'b0;
            first_q    <= 1'b1;
            pend_q     <= '0;
        end else begin
            state_q    <= state_d;
            iters_q    <= iters_d;
            reads_q    <= reads_d;
            reads_ld_q <= reads_ld_d;
            dedup_q    <= dedup_d;
            first_q    <= first_d;
            pend_q     <= pend_d;
        end
    end
endmodule
